// File: rtl/ntru_pkg.sv
// Shared NTRU-HRSS definitions: polynomial sizes, ternary coefficient
// encoding, the s3_unpack FSM state type and a base-3 digit helper.
package ntru_pkg;

    localparam int         NTRU_N  = 701;
    localparam logic [7:0] N_BYTES = 8'd140;
    localparam logic [8:0] N_BEATS = 9'd351;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b10;

    typedef enum logic [1:0] {
        S3U_IDLE = 2'd0,
        S3U_RUN  = 2'd1,
        S3U_DONE = 2'd2
    } s3u_state_t;

    // Lowest base-3 digit of v as a ternary coefficient (digit 2 means -1).
    function automatic trit_t digit_to_trit(input logic [7:0] v);
        trit_t t;
        case (v % 8'd3)
            8'd0:    t = TRIT_ZERO;
            8'd1:    t = TRIT_POS;
            default: t = TRIT_NEG;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/s3_unpack_if.sv
// Handshake bundle for s3_unpack: packed byte input, 2-coefficient beat
// output, completion pulse and non-canonical-byte flag.
interface s3_unpack_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_m;
    logic       done;
    logic       err;

    modport master (
        output start, in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_m, done, err
    );

    modport slave (
        input  start, in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_m, done, err
    );
endinterface

// File: rtl/s3_byte_decode.sv
// Combinational S3 byte decoder: one packed byte -> five ternary
// coefficients, little-endian base 3 (trit i in trits[2i+1:2i]).
module s3_byte_decode
    import ntru_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [9:0] trits
);

    // Constant divisions pick out each base-3 digit; d4 keeps the mod-3 rule
    // even for bytes above 242.
    always_comb begin
        trits[1:0] = digit_to_trit(byte_in);
        trits[3:2] = digit_to_trit(byte_in / 8'd3);
        trits[5:4] = digit_to_trit(byte_in / 8'd9);
        trits[7:6] = digit_to_trit(byte_in / 8'd27);
        trits[9:8] = digit_to_trit(byte_in / 8'd81);
    end

endmodule

// File: rtl/s3_unpack.sv
// Streaming S3 unpacker for NTRU-HRSS (N = 701): 140 packed bytes in, 351
// two-coefficient beats out, coefficient 700 and the pad slot forced to 0.
// Optional build macro: S3_UNPACK_CHK_EN enables the sticky err flag for
// accepted bytes above 242; otherwise err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S3U_IDLE | waiting for start; handshakes idle
// S3U_RUN  | accepting bytes while < 2 trits buffered, emitting beats
// S3U_DONE | one-cycle done pulse, then back to IDLE
module s3_unpack
    import ntru_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    s3_unpack_if.slave bus
);

    s3u_state_t  state_q;
    logic [2:0]  count_q;
    logic [7:0]  bytes_left_q;
    logic [8:0]  beats_left_q;
    logic [11:0] trit_buf_q;

    logic [9:0]  dec_trits;
    logic [11:0] appended;
    logic        in_ready_w;
    logic        out_valid_w;
    logic        in_fire;
    logic        out_fire;

    s3_byte_decode u_dec (
        .byte_in (bus.in_byte),
        .trits   (dec_trits)
    );

    // Handshake decode from registered state only; the last beat carries
    // coefficient 700 plus the pad slot and is issued with an empty buffer.
    always_comb begin
        in_ready_w  = (state_q == S3U_RUN) && (count_q < 3'd2) && (bytes_left_q != 8'd0);
        out_valid_w = (state_q == S3U_RUN) &&
                      ((count_q >= 3'd2) || ((bytes_left_q == 8'd0) && (beats_left_q == 9'd1)));
        in_fire     = bus.in_valid && in_ready_w;
        out_fire    = out_valid_w && bus.out_ready;
        appended    = count_q[0] ? {dec_trits, 2'b00} : {2'b00, dec_trits};
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_m     = out_valid_w ? trit_buf_q[3:0] : 4'b0000;
    assign bus.done      = (state_q == S3U_DONE);

    // FSM, trit buffer and byte/beat counters. Trits above count are always
    // zero, so appends can OR into place and the final beat reads as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S3U_IDLE;
            count_q      <= '0;
            bytes_left_q <= '0;
            beats_left_q <= '0;
            trit_buf_q   <= '0;
        end else begin
            case (state_q)
                S3U_IDLE: begin
                    if (bus.start) begin
                        state_q      <= S3U_RUN;
                        bytes_left_q <= N_BYTES;
                        beats_left_q <= N_BEATS;
                        count_q      <= '0;
                        trit_buf_q   <= '0;
                    end
                end
                S3U_RUN: begin
                    if (in_fire) begin
                        trit_buf_q   <= trit_buf_q | appended;
                        count_q      <= count_q + 3'd5;
                        bytes_left_q <= bytes_left_q - 8'd1;
                    end else if (out_fire) begin
                        trit_buf_q   <= {4'b0000, trit_buf_q[11:4]};
                        beats_left_q <= beats_left_q - 9'd1;
                        if (count_q >= 3'd2) begin
                            count_q <= count_q - 3'd2;
                        end
                        if (beats_left_q == 9'd1) begin
                            state_q <= S3U_DONE;
                        end
                    end
                end
                S3U_DONE: state_q <= S3U_IDLE;
                default:  state_q <= S3U_IDLE;
            endcase
        end
    end

`ifdef S3_UNPACK_CHK_EN
    logic err_q;

    // Sticky flag for accepted bytes outside the canonical 0..242 range.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == S3U_IDLE) && bus.start) begin
            err_q <= 1'b0;
        end else if (in_fire && (bus.in_byte > 8'd242)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/s3_unpack.md
# s3_unpack

Streaming unpacker for packed ternary polynomials in the NTRU-HRSS KEM datapath (N = 701). It accepts the 140-byte S3 encoding one byte at a time and decodes each byte into five base-3 digits. It emits the 701 ternary coefficients two per beat in 2-bit ternary format, in the order the downstream lift stage consumes them on its 4-bit `m` bus. Coefficient 700 is forced to 0.

## Interface

- `NTRU_N`, 701: polynomial length.
- `N_BYTES`, 140: packed input length, (NTRU_N-1)/5.
- `N_BEATS`, 351: output beats, ceil(NTRU_N/2).

- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `start`  in  1: begin a new polynomial; honoured only in IDLE.
- `in_valid`  in  1: `in_byte` valid.
- `in_ready`  out  1: byte accepted when `in_valid && in_ready`.
- `in_byte`  in  8: packed byte, 5 trits, little-endian base 3.
- `out_valid`  out  1: `out_m` valid.
- `out_ready`  in  1: beat consumed when `out_valid && out_ready`.
- `out_m`  out  4: [1:0] = coeff 2k, [3:2] = coeff 2k+1.
- `done`  out  1: one-cycle pulse after the final beat.
- `err`  out  1: sticky non-canonical-byte flag (see Configuration).

## Operation

- Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1. The value 2'b11 is never produced.
- Byte decode for byte c:
  - d0 = c mod 3
  - d1 = (c/3) mod 3
  - d2 = (c/9) mod 3
  - d3 = (c/27) mod 3
  - d4 = (c/81) mod 3
  - Each digit maps 0→0, 1→+1, 2→-1.
  - Byte j yields coefficients 5j..5j+4, in order d0..d4.
- Buffer: a 6-trit shift buffer with a 3-bit `count`, plus an 8-bit `bytes_left` counter and a 9-bit `beats_left` counter.
- FSM states:
  - IDLE: all ready/valid outputs low. `start` → RUN. It loads `bytes_left` = N_BYTES, `beats_left` = N_BEATS and `count` = 0, and clears `err`.
  - RUN:
    - `in_ready` = (`count` < 2) && (`bytes_left` != 0).
    - On an input fire, the 5 decoded trits are appended above the existing trits and `count` += 5.
    - `out_valid` = (`count` >= 2), or (`bytes_left` == 0 && `beats_left` == 1).
    - On an output fire, the 2 lowest trits shift out and `count` -= 2. In the final beat, coeff 700 is 0 and the pad slot is 0, so `out_m` = 4'b0000.
    - On the output fire where `beats_left` == 1 → DONE.
  - DONE: `done` = 1 for exactly one cycle, then → IDLE.
- Input and output fire never occur in the same cycle, because `in_ready` requires `count` < 2, which excludes `out_valid` except on the final beat, where `bytes_left` is 0.
- `start` while in RUN or DONE is ignored.
- `in_valid` outside RUN is ignored (not acknowledged).
- `out_valid` is held stable until accepted. `out_m` does not change while `out_valid && !out_ready`.

## Timing

- Reset values: FSM IDLE; `count`, `bytes_left` and `beats_left` = 0; `in_ready`, `out_valid`, `done` and `err` = 0; `out_m` = 0.
- A reset mid-operation aborts immediately. No `done` pulse is produced, and partial data is discarded.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Byte-to-first-beat latency: 1 cycle. A byte accepted at cycle t makes `out_valid` high at t+1.
- Throughput with no backpressure: 7 cycles per 2 bytes (2 accept cycles + 5 beats).
  - Full polynomial: `start` accepted at cycle 0, RUN from cycle 1.
  - Final beat at cycle 491.
  - `done` at cycle 492.

## Configuration

- `S3_UNPACK_CHK_EN` defined: `err` sets, sticky until the next `start` or `rst`, when any accepted byte is > 242. Decode still applies the mod-3 rule to d4.
- `S3_UNPACK_CHK_EN` undefined: `err` is tied to 0 and no comparator is instantiated.

## Structure

- Shared package `ntru_pkg` holds:
  - `NTRU_N`, `N_BYTES`, `N_BEATS`.
  - typedef `trit_t` (logic [1:0]).
  - constants `TRIT_ZERO`, `TRIT_POS`, `TRIT_NEG`.
  - FSM state enum `s3u_state_t`.
- Sub-module `s3_byte_decode`: combinational, 8-bit byte → 5 × `trit_t`. It uses constant division by 3/9/27/81 or a 256-entry case.
- The top module contains the FSM, the buffer, the counters and the handshakes.

## Test plan

- Decode byte 0x05, downstream always ready:
  - Coeffs 0..4 = -1,+1,0,0,0.
  - Beat 0 `out_m` = 4'b0110.
  - Beat 1 = 4'b0000.
  - After byte 1 (also 0x05), beat 2 = 4'b1000.
- Full run of 140 × 0xF2 (all digits -1):
  - Exactly 351 beats.
  - Beats 0..349 = 4'b1010.
  - Beat 350 = 4'b0000.
  - `done` high for one cycle at cycle 492.
- Byte 0xFF:
  - Coeffs = 0,+1,+1,0,0.
  - With `S3_UNPACK_CHK_EN`, `err` = 1 and stays high through `done`.
  - Without it, `err` = 0.
- Random `out_ready` stalls and random `in_valid` gaps:
  - `out_m` is stable while stalled.
  - The beat sequence matches the unstalled golden model.
  - `in_ready` is never high while `count` >= 2.
- Assert `rst` after beat 100:
  - All outputs return to reset values on the next cycle, with no `done` pulse.
  - A following `start` produces a correct full polynomial.
- `start` pulsed during RUN: ignored, beat count stays 351. An `in_valid` byte presented in IDLE is not acknowledged.
